cluster_sum_accumulator: RTL and testbench
==========================================

# cluster_sum_accumulator

Accumulates per-cluster colour-component sums and pixel counts over one frame pass of the K-means loop. It sits directly upstream of the 16-lane centroid divider. It consumes the (cluster index, component value) stream from the distance/assignment stage. It presents per-cluster dividends (sums), divisors (counts) and an enable mask (clusters with non-zero count) to the divider, and holds them stable until the divider reports completion.

## Interface
Parameters:
- K, 16, number of clusters (1..16); cluster index width fixed at 4
- COMP_W, 8, pixel component width
- SUM_W, 20, per-cluster sum width
- CNT_W, 12, per-cluster count width; frame holds at most 2^CNT_W-1 pixels

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a new accumulation pass; sampled only in IDLE
- pix_valid  in  1  pixel beat valid
- pix_ready  out  1  block accepts a beat this cycle
- pix_cluster  in  4  assigned cluster index of the beat
- pix_value  in  COMP_W  component value of the beat
- pix_last  in  1  beat is the last pixel of the frame
- sums_valid  out  1  sum/count/en outputs are final and stable
- ack  in  1  downstream divider done (all_ready); releases DONE
- en  out  K  bit k = (count[k] != 0), qualified by sums_valid
- sum_flat  out  K*SUM_W  sum[k] at bits [k*SUM_W +: SUM_W]
- count_flat  out  K*CNT_W  count[k] at bits [k*CNT_W +: CNT_W]
- err  out  1  sticky per pass: count saturation or out-of-range index

## Operation
- FSM: IDLE -> CLEAR -> ACCUM -> DONE -> IDLE.
- IDLE: pix_ready=0, sums_valid=0. Registers keep their last-pass values. start=1 -> CLEAR.
- CLEAR, one cycle: all sum[k], count[k] and err zeroed. Go to ACCUM.
- ACCUM: pix_ready=1. On pix_valid&pix_ready:
  - sum[c] += zero-extended pix_value and count[c] += 1, where c=pix_cluster.
  - If c >= K: beat dropped, err set.
  - If count[c] == 2^CNT_W-1: both sum and count hold, err set. No wrap in either field.
  - If pix_last: go to DONE.
- DONE: pix_ready=0, sums_valid=1. en, sum_flat and count_flat are frozen. ack=1 -> IDLE.
- ack outside DONE is ignored. start outside IDLE is ignored.
- Sum width rule: (2^CNT_W-1)*(2^COMP_W-1) < 2^SUM_W. Elaboration fails if this is violated.
- Reset: FSM to IDLE, all sums, counts and err to 0. This applies mid-pass too; a partial pass is discarded.

## Timing
- Reset values: pix_ready=0, sums_valid=0, en=0, sum_flat=0, count_flat=0, err=0.
- start sampled high in IDLE at edge n: CLEAR during cycle n+1, pix_ready=1 from cycle n+2.
- An accepted beat at edge m is visible on sum_flat/count_flat after edge m.
- Back-to-back beats to the same cluster accumulate every cycle with no bubble.
- pix_last accepted at edge m: sums_valid=1 and pix_ready=0 from cycle m+1, including the last beat's update.
- ack high at edge p in DONE: sums_valid=0 from cycle p+1. Outputs keep their values in IDLE.
- Minimum pass with one pixel: start -> sums_valid in 3 edges.

## Structure
- Shared package kmeans_pkg: K, COMP_W, SUM_W, CNT_W constants and the FSM state enum (also used by the divider-side controller).
- One sub-module, cluster_acc_lane: a single cluster's sum/count registers with clear, increment and saturation. The top instantiates K lanes plus the FSM and index decode.

## Test plan
- Reset during ACCUM after 5 beats -> all outputs 0, state IDLE. A later start runs a clean pass.
- start; beats (c=0,v=10), (c=0,v=20), (c=3,v=255) with last on the third -> sums_valid; sum0=30, count0=2, sum3=255, count3=1, en=16'h0009, err=0.
- 4095 beats c=7, v=255, then a 4096th beat c=7 with last -> count7=4095, sum7=1044225, err=1.
- Beat with c=12 when K=10 -> no sum/count change, err=1, en unaffected.
- pix_valid toggling every other cycle, same cluster, 6 beats of v=1 -> sum=6, count=6. pix_ready stays 1 throughout ACCUM.
- In DONE, hold ack=0 for 20 cycles while driving pix_valid and start -> outputs unchanged. Then ack=1 -> sums_valid=0 next cycle, values retained.

Source files
------------

// File: rtl/cluster_sum_accumulator_pkg.sv
// Shared K-means constants and the accumulation-pass state encoding.
// The divider-side controller imports the same package, so the state enum
// and default widths are defined once here.
package kmeans_pkg;

  // Default clusters, component width, per-cluster sum and count widths.
  localparam int KM_K      = 16;
  localparam int KM_COMP_W = 8;
  localparam int KM_SUM_W  = 20;
  localparam int KM_CNT_W  = 12;
  // Cluster index width is fixed whatever K is.
  localparam int KM_IDX_W  = 4;

  // One accumulation pass: clear the lanes, accumulate a frame, then hold
  // results for the divider until it acknowledges.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_e;

  // A full-count cluster of maximum-value components must still fit in a sum.
  function automatic bit sum_width_ok(input int comp_w, input int sum_w, input int cnt_w);
    longint max_sum;
    max_sum = ((longint'(1) << cnt_w) - 1) * ((longint'(1) << comp_w) - 1);
    return max_sum < (longint'(1) << sum_w);
  endfunction

endpackage

// File: rtl/cluster_sum_accumulator_if.sv
// Pixel stream in, per-cluster results out.
//
// Handshake: a pixel beat transfers on a rising clk edge where pix_valid and
// pix_ready are both 1. The producer holds pix_cluster/pix_value/pix_last
// stable while pix_valid=1 and pix_ready=0; pix_ready does not depend on
// pix_valid. Results are meaningful while sums_valid=1 and stay frozen until
// ack is seen high on a rising edge; ack has no effect while sums_valid=0.
interface cluster_sum_accumulator_if #(
  parameter int K      = kmeans_pkg::KM_K,
  parameter int COMP_W = kmeans_pkg::KM_COMP_W,
  parameter int SUM_W  = kmeans_pkg::KM_SUM_W,
  parameter int CNT_W  = kmeans_pkg::KM_CNT_W
);

  logic                           pix_valid;
  logic                           pix_ready;
  logic [kmeans_pkg::KM_IDX_W-1:0] pix_cluster;
  logic [COMP_W-1:0]              pix_value;
  logic                           pix_last;

  logic                           sums_valid;
  logic                           ack;
  logic [K-1:0]                   en;
  logic [K*SUM_W-1:0]             sum_flat;
  logic [K*CNT_W-1:0]             count_flat;

  // Upstream assignment stage plus the downstream divider.
  modport master (
    output pix_valid, pix_cluster, pix_value, pix_last, ack,
    input  pix_ready, sums_valid, en, sum_flat, count_flat
  );

  // The accumulator itself.
  modport slave (
    input  pix_valid, pix_cluster, pix_value, pix_last, ack,
    output pix_ready, sums_valid, en, sum_flat, count_flat
  );

endinterface

// File: rtl/cluster_sum_accumulator_lane.sv
// One cluster's running sum and pixel count. Clear wins over increment; a
// full count freezes both fields so neither wraps.
module cluster_acc_lane #(
  parameter int COMP_W = kmeans_pkg::KM_COMP_W,
  parameter int SUM_W  = kmeans_pkg::KM_SUM_W,
  parameter int CNT_W  = kmeans_pkg::KM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic [COMP_W-1:0] value_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              sat_o
);

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat;

  assign sat = (count_q == {CNT_W{1'b1}});

  // Next sum/count: clear, accumulate one beat, or hold when saturated.
  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    if (clear_i) begin
      sum_d   = '0;
      count_d = '0;
    end else if (inc_i && !sat) begin
      sum_d   = sum_q + SUM_W'(value_i);
      count_d = count_q + CNT_W'(1);
    end
  end

  // Lane registers; reset discards any partial pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  assign sum_o   = sum_q;
  assign count_o = count_q;
  assign sat_o   = sat;

endmodule

// File: rtl/cluster_sum_accumulator.sv
// Per-cluster sum/count accumulator for one K-means frame pass. Decodes the
// cluster index of each accepted beat onto K lanes, tracks the pass state and
// a sticky error, and presents frozen results to the centroid divider.
module cluster_sum_accumulator
  import kmeans_pkg::*;
#(
  parameter int K      = kmeans_pkg::KM_K,
  parameter int COMP_W = kmeans_pkg::KM_COMP_W,
  parameter int SUM_W  = kmeans_pkg::KM_SUM_W,
  parameter int CNT_W  = kmeans_pkg::KM_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  cluster_sum_accumulator_if.slave   bus,
  output logic                       err,
  output acc_state_e                 dbg_state
);

  // Reject configurations that could wrap a sum or exceed the index range.
  if (!sum_width_ok(COMP_W, SUM_W, CNT_W)) begin : g_sum_w_bad
    $error("cluster_sum_accumulator: SUM_W too narrow for COMP_W/CNT_W");
  end
  if (K < 1 || K > (1 << KM_IDX_W)) begin : g_k_bad
    $error("cluster_sum_accumulator: K out of range");
  end

  acc_state_e state_q, state_d;
  logic       pix_ready, sums_valid, clear, accept;
  logic       in_range, sat_hit;
  logic       err_q, err_d;

  logic [K-1:0]     hit;
  logic [K-1:0]     lane_sat;
  logic [SUM_W-1:0] lane_sum [K];
  logic [CNT_W-1:0] lane_cnt [K];

  logic [K-1:0]       en_w;
  logic [K*SUM_W-1:0] sum_flat_w;
  logic [K*CNT_W-1:0] count_flat_w;

  // Pass state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: start only matters in IDLE, ack only in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_ACCUM;
      ST_ACCUM: if (accept && bus.pix_last) state_d = ST_DONE;
      ST_DONE:  if (bus.ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded controls for the stream, the result qualifier and the lanes.
  always_comb begin
    pix_ready  = 1'b0;
    sums_valid = 1'b0;
    clear      = 1'b0;
    unique case (state_q)
      ST_CLEAR: clear      = 1'b1;
      ST_ACCUM: pix_ready  = 1'b1;
      ST_DONE:  sums_valid = 1'b1;
      default:  ;
    endcase
  end

  assign accept   = bus.pix_valid & pix_ready;
  assign in_range = ({1'b0, bus.pix_cluster} < (KM_IDX_W + 1)'(K));

  // One-hot lane select for the accepted beat; out-of-range beats hit nothing.
  always_comb begin
    hit = '0;
    for (int k = 0; k < K; k++) begin
      hit[k] = accept && in_range && (bus.pix_cluster == KM_IDX_W'(k));
    end
  end

  assign sat_hit = |(hit & lane_sat);

  // Sticky pass error: dropped index or a beat landing on a full count.
  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (accept && (!in_range || sat_hit)) begin
      err_d = 1'b1;
    end
  end

  // Error register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  for (genvar k = 0; k < K; k++) begin : g_lane
    cluster_acc_lane #(
      .COMP_W (COMP_W),
      .SUM_W  (SUM_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear),
      .inc_i   (hit[k]),
      .value_i (bus.pix_value),
      .sum_o   (lane_sum[k]),
      .count_o (lane_cnt[k]),
      .sat_o   (lane_sat[k])
    );
  end

  // Flatten lane registers and derive the non-empty cluster mask.
  always_comb begin
    en_w         = '0;
    sum_flat_w   = '0;
    count_flat_w = '0;
    for (int k = 0; k < K; k++) begin
      en_w[k]                        = |lane_cnt[k];
      sum_flat_w[k*SUM_W +: SUM_W]   = lane_sum[k];
      count_flat_w[k*CNT_W +: CNT_W] = lane_cnt[k];
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.sums_valid = sums_valid;
  assign bus.en         = en_w;
  assign bus.sum_flat   = sum_flat_w;
  assign bus.count_flat = count_flat_w;
  assign err            = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cluster_sum_accumulator.sv
// Bench for cluster_sum_accumulator with K=10 so out-of-range indices exist.
// Reference model: plain per-cluster integer sums/counts updated per beat.
module tb_cluster_sum_accumulator;
  import kmeans_pkg::*;

  localparam int K       = 10;
  localparam int COMP_W  = 8;
  localparam int SUM_W   = 20;
  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       err;
  acc_state_e dbg_state;

  always #5 clk = ~clk;

  cluster_sum_accumulator_if #(.K(K), .COMP_W(COMP_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) bus ();

  cluster_sum_accumulator #(.K(K), .COMP_W(COMP_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int m_sum [K];
  int m_cnt [K];
  bit m_err;
  logic [SUM_W+CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < K; k++) begin
      m_sum[k] = 0;
      m_cnt[k] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_beat(input int c, input int v);
    if (c >= K) m_err = 1'b1;
    else if (m_cnt[c] == CNT_MAX) m_err = 1'b1;
    else begin
      m_sum[c] += v;
      m_cnt[c] += 1;
    end
  endtask

  // Compare every cluster's sum/count, err, and (when valid) the en mask.
  task automatic check_results(input string tag, input bit exp_valid);
    logic [SUM_W+CNT_W-1:0] e;
    logic [K-1:0] exp_en;
    check($sformatf("%s_sums_valid", tag), bus.sums_valid, exp_valid);
    exp_q = {};
    exp_en = '0;
    for (int k = 0; k < K; k++) begin
      exp_q.push_back({SUM_W'(m_sum[k]), CNT_W'(m_cnt[k])});
      if (m_cnt[k] != 0) exp_en[k] = 1'b1;
    end
    for (int k = 0; k < K; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_sum%0d", tag, k), bus.sum_flat[k*SUM_W +: SUM_W], e[CNT_W +: SUM_W]);
      check($sformatf("%s_cnt%0d", tag, k), bus.count_flat[k*CNT_W +: CNT_W], e[CNT_W-1:0]);
    end
    if (exp_valid) check($sformatf("%s_en", tag), bus.en, exp_en);
    check($sformatf("%s_err", tag), err, m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_pass(input string tag);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.ack       = 1'b0;
    start         = 1'b1;
    check($sformatf("%s_idle_state", tag), dbg_state, ST_IDLE);
    check($sformatf("%s_idle_ready", tag), bus.pix_ready, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s_clear_state", tag), dbg_state, ST_CLEAR);
    check($sformatf("%s_clear_ready", tag), bus.pix_ready, 1'b0);
    model_clear();
  endtask

  // One beat; noise randomly raises start/ack, which ACCUM must ignore.
  task automatic send_beat(input int c, input int v, input bit last, input bit noise);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.pix_valid   = 1'b1;
    bus.pix_cluster = 4'(c);
    bus.pix_value   = COMP_W'(v);
    bus.pix_last    = last;
    start           = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.ack         = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    while (!bus.pix_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("beat_ready", bus.pix_ready, 1'b1);
    if (bus.pix_ready) model_beat(c, v);
    @(posedge clk);
  endtask

  task automatic drive_gap(input bit noise);
    @(negedge clk);
    bus.pix_valid   = 1'b0;
    bus.pix_last    = 1'b0;
    bus.pix_cluster = 4'($urandom_range(0, 15));
    start           = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.ack         = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    check("gap_ready", bus.pix_ready, 1'b1);
    @(posedge clk);
  endtask

  // Enter DONE check, then hold ack low while toggling other inputs.
  task automatic finish_pass(input string tag, input int hold);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.pix_last  = 1'b0;
    start         = 1'b0;
    bus.ack       = 1'b0;
    check($sformatf("%s_done_state", tag), dbg_state, ST_DONE);
    check($sformatf("%s_done_ready", tag), bus.pix_ready, 1'b0);
    check_results($sformatf("%s_done", tag), 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.pix_valid   = 1'($urandom_range(0, 1));
      bus.pix_cluster = 4'($urandom_range(0, 15));
      bus.pix_value   = COMP_W'($urandom_range(0, 255));
      start           = 1'b1;
    end
    if (hold > 0) begin
      @(negedge clk);
      bus.pix_valid = 1'b0;
      start         = 1'b0;
      check_results($sformatf("%s_hold", tag), 1'b1);
    end
  endtask

  task automatic release_done(input string tag);
    @(negedge clk);
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    check($sformatf("%s_rel_state", tag), dbg_state, ST_IDLE);
    check_results($sformatf("%s_rel", tag), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int c;
    bus.pix_valid   = 1'b0;
    bus.pix_cluster = '0;
    bus.pix_value   = '0;
    bus.pix_last    = 1'b0;
    bus.ack         = 1'b0;
    model_clear();

    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ready", bus.pix_ready, 1'b0);
    check("rst_valid", bus.sums_valid, 1'b0);
    check("rst_en", bus.en, '0);
    check("rst_sum", bus.sum_flat, '0);
    check("rst_cnt", bus.count_flat, '0);
    check("rst_err", err, 1'b0);
    reset = 1'b1;

    // Reset in the middle of ACCUM discards the partial pass.
    start_pass("midrst");
    for (int i = 0; i < 5; i++) send_beat(i % K, 17 + i, 1'b0, 1'b0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    reset = 1'b0;
    #1;
    model_clear();
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_ready", bus.pix_ready, 1'b0);
    check("midrst_en", bus.en, '0);
    check("midrst_sum", bus.sum_flat, '0);
    check("midrst_cnt", bus.count_flat, '0);
    check_results("midrst", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Directed three-beat pass.
    start_pass("dir");
    send_beat(0, 10, 1'b0, 1'b0);
    send_beat(0, 20, 1'b0, 1'b0);
    send_beat(3, 255, 1'b1, 1'b0);
    finish_pass("dir", 0);
    check("dir_sum0", bus.sum_flat[0 +: SUM_W], 30);
    check("dir_cnt0", bus.count_flat[0 +: CNT_W], 2);
    check("dir_sum3", bus.sum_flat[3*SUM_W +: SUM_W], 255);
    check("dir_cnt3", bus.count_flat[3*CNT_W +: CNT_W], 1);
    check("dir_en", bus.en, 10'h009);
    check("dir_err", err, 1'b0);
    release_done("dir");

    // Out-of-range index is dropped and flagged.
    start_pass("oor");
    send_beat(0, 5, 1'b0, 1'b0);
    send_beat(12, 100, 1'b0, 1'b0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    check("oor_mid_err", err, 1'b1);
    check_results("oor_mid", 1'b0);
    send_beat(0, 5, 1'b1, 1'b0);
    finish_pass("oor", 0);
    check("oor_en", bus.en, 10'h001);
    check("oor_sum0", bus.sum_flat[0 +: SUM_W], 10);
    check("oor_cnt0", bus.count_flat[0 +: CNT_W], 2);
    check("oor_err", err, 1'b1);
    release_done("oor");

    // Valid toggling every other cycle; ready stays high in the gaps.
    start_pass("tog");
    for (int i = 0; i < 6; i++) begin
      send_beat(2, 1, i == 5, 1'b0);
      if (i < 5) drive_gap(1'b0);
    end
    finish_pass("tog", 20);
    check("tog_sum2", bus.sum_flat[2*SUM_W +: SUM_W], 6);
    check("tog_cnt2", bus.count_flat[2*CNT_W +: CNT_W], 6);
    release_done("tog");

    // Count saturation on cluster 7.
    start_pass("sat");
    for (int i = 0; i < CNT_MAX; i++) send_beat(7, 255, 1'b0, 1'b0);
    send_beat(7, 255, 1'b1, 1'b0);
    finish_pass("sat", 0);
    check("sat_cnt7", bus.count_flat[7*CNT_W +: CNT_W], 4095);
    check("sat_sum7", bus.sum_flat[7*SUM_W +: SUM_W], 1044225);
    check("sat_err", err, 1'b1);
    release_done("sat");

    // Randomized passes with gaps and ignored start/ack noise.
    for (int p = 0; p < 4; p++) begin
      start_pass($sformatf("rnd%0d", p));
      n = $urandom_range(20, 60);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) drive_gap(1'b1);
        c = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, K - 1);
        send_beat(c, $urandom_range(0, 255), i == n - 1, 1'b1);
      end
      finish_pass($sformatf("rnd%0d", p), $urandom_range(0, 3));
      release_done($sformatf("rnd%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
